bus_arbiter: RTL and testbench
==============================

# bus_arbiter

Two-master arbiter that shares the single femto peripheral bus between the core (master 0) and a second requester such as a DMA engine (master 1). It sits between the requesters and the address decoder / slave controllers. It buffers one pulsed request per master, grants one transaction at a time, and routes `resp`, `rdata` and `fault` back to the owning master.

## Interface
- `ADDR_W`, default `` `XLEN ``: bus address width.
- `DATA_W`, default `` `BUS_WIDTH ``: bus data width.
- `ACC_W`, default `` $clog2(`BUS_ACC_CNT) ``: access-size field width.
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `m0_addr`/`m1_addr`  in  ADDR_W  master request address.
- `m0_w_rb`/`m1_w_rb`  in  1  1 = write, 0 = read.
- `m0_acc`/`m1_acc`  in  ACC_W  access size.
- `m0_wdata`/`m1_wdata`  in  DATA_W  write data.
- `m0_req`/`m1_req`  in  1  one-cycle request pulse; all fields are valid in that cycle only.
- `m0_rdata`/`m1_rdata`  out  DATA_W  read data; valid with `mX_resp`.
- `m0_resp`/`m1_resp`  out  1  one-cycle completion pulse.
- `m0_fault`/`m1_fault`  out  1  one-cycle fault pulse.
- `s_addr`, `s_w_rb`, `s_acc`, `s_wdata`  out  as above  downstream request fields; registered.
- `s_req`  out  1  downstream one-cycle request pulse; registered.
- `s_rdata`  in  DATA_W  downstream read data.
- `s_resp`  in  1  downstream completion pulse.
- `s_fault`  in  1  downstream fault; meaningful only in the `s_req` cycle.

## Operation
- Each master has one capture slot (`pend`, addr, w_rb, acc, wdata). A slot loads on `mX_req` and clears when its request is granted.
- FSM has two states: IDLE and BUSY. `owner` records the granted master.
- IDLE: if any slot is pending, or any `mX_req` arrives this cycle (bypass), select a winner:
  - register its fields onto `s_*`
  - pulse `s_req` next cycle
  - set `owner`, go to BUSY.
- BUSY: `mX_resp` = `s_resp & (owner==X)`. `mX_rdata` = `s_rdata` (pass-through for both masters).
- BUSY exits to IDLE on either:
  - `s_resp`, or
  - `s_fault` in the `s_req` cycle. In that case `mX_fault` pulses for the owner, and no `resp` follows.
- In the cycle `s_resp` is seen, arbitration runs as in IDLE, so a back-to-back `s_req` appears the next cycle.
- Protocol violation: an `mX_req` while that master's slot is pending or its transaction is outstanding.
  - The request is dropped.
  - `mX_fault` pulses in the same cycle (combinational).
  - Arbiter state is unchanged.
- Simultaneous `m0_req` and `m1_req` in IDLE: both are captured; arbitration (see Configuration) grants one, and the other stays pending.
- `s_resp` while IDLE (spurious) is ignored; no `mX_resp`.
- Reset values: all `s_*` = 0, all `mX_resp`/`mX_fault` = 0, slots cleared, state IDLE, `last_grant` = 1.
- Reset mid-transaction: the outstanding transaction and pending slots are discarded. `s_resp`/`s_fault` in the reset cycle are ignored.

## Timing
- Idle-bus request latency: `mX_req` at cycle N → `s_req` at N+1.
- Response latency: `s_resp` at cycle K → `mX_resp`/`mX_rdata` at K (zero added latency).
- Fault: `s_fault` at N+1 → `mX_fault` at N+1.
- Loser wait: granted no earlier than the cycle after the winner's `s_resp`.
- At most one transaction is outstanding downstream.

## Configuration
- `BUS_ARB_RR_EN` defined: round-robin. When both masters contend, grant the master ≠ `last_grant`, then update `last_grant`. After reset, m0 wins first contention.
- `BUS_ARB_RR_EN` undefined: fixed priority, m0 always wins. `last_grant` is not implemented.

## Structure
- Shared header `femto.vh` holds `XLEN`, `BUS_WIDTH`, `BUS_ACC_CNT`, plus new `BUS_ARB_M0`=0 and `BUS_ARB_M1`=1 owner encodings.
- One sub-module, `bus_req_slot`, instantiated twice: the per-master capture register with pend flag and violation detect.
- The arbitration FSM and `owner` logic live in `bus_arbiter`.

## Test plan
- m0 read addr 0x0000_0100, `s_resp` 3 cycles after `s_req` with `s_rdata`=0xDEADBEEF → `s_req` at N+1; `m0_resp`=1 and `m0_rdata`=0xDEADBEEF at N+4; `m1_resp` stays 0.
- `m0_req` and `m1_req` same cycle, RR build → m0 granted first, m1 `s_req` the cycle after m0's `s_resp`. Repeat → m1 first. Fixed build → m0 first both times.
- m1 write to an unmapped address, `s_fault`=1 in the `s_req` cycle → `m1_fault` pulse that cycle; arbiter returns to IDLE; a following m0 request issues normally.
- `m0_req` while m0 outstanding → `m0_fault` pulse same cycle; downstream sees no second `s_req`; original `m0_resp` still delivered.
- `rst`=1 while BUSY with m1 pending → all outputs 0 the next cycle; a later `s_resp` produces no `mX_resp`; a fresh m0 request is issued at N+1.

Source files
------------

// File: rtl/bus_arbiter_pkg.sv
// bus_arbiter_pkg
// Shared definitions for the two-master peripheral bus arbiter:
//   XLEN / BUS_WIDTH / BUS_ACC_CNT : default bus geometry
//   BUS_ARB_M0 / BUS_ARB_M1        : owner encodings for master 0 / master 1
//   arb_state_t                    : arbitration FSM states
//   pick_winner()                  : arbitration decision between two requesters
package bus_arbiter_pkg;

    localparam int XLEN        = 32;
    localparam int BUS_WIDTH   = 32;
    localparam int BUS_ACC_CNT = 4;

    localparam logic BUS_ARB_M0 = 1'b0;
    localparam logic BUS_ARB_M1 = 1'b1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_t;

    // With rr_en set, contention goes to the master that did not win the
    // previous contention; otherwise master 0 always wins.
    function automatic logic pick_winner(input logic avail0,
                                         input logic avail1,
                                         input logic last_grant,
                                         input logic rr_en);
        logic win;
        if (avail0 && avail1)
            win = rr_en ? ~last_grant : BUS_ARB_M0;
        else
            win = avail0 ? BUS_ARB_M0 : BUS_ARB_M1;
        return win;
    endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// bus_arbiter_if
// One femto bus channel (request fields + response). Used for each master
// port and for the downstream port of the arbiter.
//   addr/w_rb/acc/wdata/req : request, driven by the requester side
//   rdata/resp/fault        : response, driven by the responder side
// Modports:
//   master : requester view (drives request, receives response)
//   slave  : responder view (receives request, drives response)
interface bus_arbiter_if
    import bus_arbiter_pkg::*;
#(
    parameter int ADDR_W = XLEN,
    parameter int DATA_W = BUS_WIDTH,
    parameter int ACC_W  = $clog2(BUS_ACC_CNT)
);
    logic [ADDR_W-1:0] addr;
    logic              w_rb;
    logic [ACC_W-1:0]  acc;
    logic [DATA_W-1:0] wdata;
    logic              req;
    logic [DATA_W-1:0] rdata;
    logic              resp;
    logic              fault;

    modport master (
        output addr, w_rb, acc, wdata, req,
        input  rdata, resp, fault
    );

    modport slave (
        input  addr, w_rb, acc, wdata, req,
        output rdata, resp, fault
    );
endinterface

// File: rtl/bus_req_slot.sv
// bus_req_slot
// Per-master capture slot: buffers one pulsed request until it is granted
// and flags requests that arrive while the master already has one pending
// or outstanding.
// Ports:
//   clk, rst                   : clock, synchronous active-high reset
//   req, addr, w_rb, acc, wdata: incoming request pulse and fields
//   busy                       : this master's transaction is outstanding
//   grant                      : the arbiter takes the request this cycle
//   avail                      : a request is available (stored or bypass)
//   viol                       : protocol violation, request dropped
//   sel_*                      : fields of the available request
module bus_req_slot
    import bus_arbiter_pkg::*;
#(
    parameter int ADDR_W = XLEN,
    parameter int DATA_W = BUS_WIDTH,
    parameter int ACC_W  = $clog2(BUS_ACC_CNT)
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic [ADDR_W-1:0] addr,
    input  logic              w_rb,
    input  logic [ACC_W-1:0]  acc,
    input  logic [DATA_W-1:0] wdata,
    input  logic              busy,
    input  logic              grant,
    output logic              avail,
    output logic              viol,
    output logic [ADDR_W-1:0] sel_addr,
    output logic              sel_w_rb,
    output logic [ACC_W-1:0]  sel_acc,
    output logic [DATA_W-1:0] sel_wdata
);
    logic              pend;
    logic [ADDR_W-1:0] addr_q;
    logic              w_rb_q;
    logic [ACC_W-1:0]  acc_q;
    logic [DATA_W-1:0] wdata_q;

    assign viol  = req & (pend | busy);
    assign avail = pend | (req & ~viol);

    // A fresh request is offered directly (bypass) so an idle bus issues it
    // on the next cycle without first going through the slot.
    assign sel_addr  = pend ? addr_q  : addr;
    assign sel_w_rb  = pend ? w_rb_q  : w_rb;
    assign sel_acc   = pend ? acc_q   : acc;
    assign sel_wdata = pend ? wdata_q : wdata;

    always_ff @(posedge clk) begin
        if (rst)
            pend <= 1'b0;
        else if (grant)
            pend <= 1'b0;   // a bypassed request granted the same cycle is consumed
        else if (req && !viol)
            pend <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (req && !viol && !grant) begin
            addr_q  <= addr;
            w_rb_q  <= w_rb;
            acc_q   <= acc;
            wdata_q <= wdata;
        end
    end
endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter
// Shares the femto peripheral bus between master 0 (core) and master 1
// (e.g. DMA). One transaction is outstanding downstream at a time; the
// response and fault are routed back to the owning master.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   m0, m1   : master channels (slave modport: requests in, responses out)
//   s        : downstream channel (master modport: registered request out)
// Configuration:
//   BUS_ARB_RR_EN defined   : round-robin on contention (m0 first after reset)
//   BUS_ARB_RR_EN undefined : fixed priority, m0 always wins
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int ADDR_W = XLEN,
    parameter int DATA_W = BUS_WIDTH,
    parameter int ACC_W  = $clog2(BUS_ACC_CNT)
)(
    input  logic          clk,
    input  logic          rst,
    bus_arbiter_if.slave  m0,
    bus_arbiter_if.slave  m1,
    bus_arbiter_if.master s
);
    arb_state_t state, state_nxt;
    logic       owner, owner_nxt;

    logic              avail0, avail1, viol0, viol1;
    logic              busy0, busy1, grant0, grant1, grant_any;
    logic              winner, arb_en, done, flt_exit;
    logic [ADDR_W-1:0] sel0_addr, sel1_addr;
    logic              sel0_w_rb, sel1_w_rb;
    logic [ACC_W-1:0]  sel0_acc, sel1_acc;
    logic [DATA_W-1:0] sel0_wdata, sel1_wdata;

    logic [ADDR_W-1:0] s_addr_q;
    logic              s_w_rb_q;
    logic [ACC_W-1:0]  s_acc_q;
    logic [DATA_W-1:0] s_wdata_q;
    logic              s_req_q;

    bus_req_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ACC_W(ACC_W)) u_slot0 (
        .clk(clk), .rst(rst),
        .req(m0.req), .addr(m0.addr), .w_rb(m0.w_rb), .acc(m0.acc), .wdata(m0.wdata),
        .busy(busy0), .grant(grant0),
        .avail(avail0), .viol(viol0),
        .sel_addr(sel0_addr), .sel_w_rb(sel0_w_rb), .sel_acc(sel0_acc), .sel_wdata(sel0_wdata)
    );

    bus_req_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ACC_W(ACC_W)) u_slot1 (
        .clk(clk), .rst(rst),
        .req(m1.req), .addr(m1.addr), .w_rb(m1.w_rb), .acc(m1.acc), .wdata(m1.wdata),
        .busy(busy1), .grant(grant1),
        .avail(avail1), .viol(viol1),
        .sel_addr(sel1_addr), .sel_w_rb(sel1_w_rb), .sel_acc(sel1_acc), .sel_wdata(sel1_wdata)
    );

    assign busy0 = (state == ST_BUSY) && (owner == BUS_ARB_M0);
    assign busy1 = (state == ST_BUSY) && (owner == BUS_ARB_M1);

    // Completion, or a decode fault reported alongside the downstream request.
    assign done     = (state == ST_BUSY) && s.resp;
    assign flt_exit = (state == ST_BUSY) && s_req_q && s.fault;

    // Arbitrate when idle, and also on the completion cycle so a waiting
    // request goes out back-to-back.
    assign arb_en    = !rst && ((state == ST_IDLE) || done);
    assign grant_any = arb_en && (avail0 || avail1);
    assign grant0    = grant_any && (winner == BUS_ARB_M0);
    assign grant1    = grant_any && (winner == BUS_ARB_M1);

`ifdef BUS_ARB_RR_EN
    logic last_grant;

    always_ff @(posedge clk) begin
        if (rst)
            last_grant <= BUS_ARB_M1;
        else if (grant_any && avail0 && avail1)
            last_grant <= winner;   // only contention moves the pointer
    end

    assign winner = pick_winner(avail0, avail1, last_grant, 1'b1);
`else
    assign winner = pick_winner(avail0, avail1, 1'b0, 1'b0);
`endif

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        if (grant_any)
            owner_nxt = winner;
        case (state)
            ST_IDLE: begin
                if (grant_any)
                    state_nxt = ST_BUSY;
            end
            ST_BUSY: begin
                if (done)
                    state_nxt = grant_any ? ST_BUSY : ST_IDLE;
                else if (flt_exit)
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            owner     <= BUS_ARB_M0;
            s_req_q   <= 1'b0;
            s_addr_q  <= '0;
            s_w_rb_q  <= 1'b0;
            s_acc_q   <= '0;
            s_wdata_q <= '0;
        end else begin
            state   <= state_nxt;
            owner   <= owner_nxt;
            s_req_q <= grant_any;
            if (grant_any) begin
                s_addr_q  <= (winner == BUS_ARB_M0) ? sel0_addr  : sel1_addr;
                s_w_rb_q  <= (winner == BUS_ARB_M0) ? sel0_w_rb  : sel1_w_rb;
                s_acc_q   <= (winner == BUS_ARB_M0) ? sel0_acc   : sel1_acc;
                s_wdata_q <= (winner == BUS_ARB_M0) ? sel0_wdata : sel1_wdata;
            end
        end
    end

    assign s.req   = s_req_q;
    assign s.addr  = s_addr_q;
    assign s.w_rb  = s_w_rb_q;
    assign s.acc   = s_acc_q;
    assign s.wdata = s_wdata_q;

    // Responses are combinational pass-through; anything seen during reset
    // is suppressed.
    assign m0.rdata = s.rdata;
    assign m1.rdata = s.rdata;
    assign m0.resp  = !rst && busy0 && s.resp;
    assign m1.resp  = !rst && busy1 && s.resp;
    assign m0.fault = !rst && (viol0 || (busy0 && flt_exit));
    assign m1.fault = !rst && (viol1 || (busy1 && flt_exit));
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter
// Directed stimulus for bus_arbiter; expected downstream requests and
// master responses/faults are queued with their cycle and matched by a
// monitor that samples on the falling clock edge.
module tb_bus_arbiter;
    import bus_arbiter_pkg::*;

    localparam int K_SREQ   = 0;
    localparam int K_M0RESP = 1;
    localparam int K_M1RESP = 2;
    localparam int K_M0FLT  = 3;
    localparam int K_M1FLT  = 4;

    typedef struct {
        int           kind;
        int           cyc;
        logic [127:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t exp_q[$];

    bus_arbiter_if #(.ADDR_W(32), .DATA_W(32), .ACC_W(2)) m0_bus ();
    bus_arbiter_if #(.ADDR_W(32), .DATA_W(32), .ACC_W(2)) m1_bus ();
    bus_arbiter_if #(.ADDR_W(32), .DATA_W(32), .ACC_W(2)) s_bus ();

    bus_arbiter #(.ADDR_W(32), .DATA_W(32), .ACC_W(2)) dut (
        .clk(clk),
        .rst(rst),
        .m0(m0_bus),
        .m1(m1_bus),
        .s(s_bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic string kname(input int k);
        case (k)
            K_SREQ:   return "s_req";
            K_M0RESP: return "m0_resp";
            K_M1RESP: return "m1_resp";
            K_M0FLT:  return "m0_fault";
            default:  return "m1_fault";
        endcase
    endfunction

    function automatic logic [127:0] pack_req(input logic [31:0] a, input logic w,
                                              input logic [1:0] acc, input logic [31:0] wd);
        return {61'd0, wd, acc, w, a};
    endfunction

    task automatic push(input int kind, input int c, input logic [127:0] data);
        exp_t e;
        e.kind = kind;
        e.cyc  = c;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic observe(input int kind, input logic [127:0] data);
        int idx;
        idx = -1;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (idx < 0 && exp_q[i].kind == kind && exp_q[i].cyc == cyc)
                idx = i;
        end
        n_cmp++;
        if (idx < 0) begin
            n_bad++;
            $display("FAIL %s: seen at cycle %0d data %0h, but no such event was expected",
                     kname(kind), cyc, data);
        end else begin
            if (exp_q[idx].data !== data) begin
                n_bad++;
                $display("FAIL %s data: cycle %0d got %0h, expected %0h",
                         kname(kind), cyc, data, exp_q[idx].data);
            end
            exp_q.delete(idx);
        end
    endtask

    task automatic expire(input int upto);
        int i;
        i = 0;
        while (i < exp_q.size()) begin
            if (exp_q[i].cyc <= upto) begin
                n_cmp++;
                n_bad++;
                $display("FAIL %s missing: expected at cycle %0d data %0h, got nothing",
                         kname(exp_q[i].kind), exp_q[i].cyc, exp_q[i].data);
                exp_q.delete(i);
            end else begin
                i++;
            end
        end
    endtask

    // Monitor: every output pulse must match a queued expectation.
    always @(negedge clk) begin
        if (s_bus.req === 1'b1)
            observe(K_SREQ, pack_req(s_bus.addr, s_bus.w_rb, s_bus.acc, s_bus.wdata));
        if (m0_bus.resp === 1'b1) observe(K_M0RESP, {96'd0, m0_bus.rdata});
        if (m1_bus.resp === 1'b1) observe(K_M1RESP, {96'd0, m1_bus.rdata});
        if (m0_bus.fault === 1'b1) observe(K_M0FLT, 128'd0);
        if (m1_bus.fault === 1'b1) observe(K_M1FLT, 128'd0);
        expire(cyc);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
        n_cmp++;
        if (act !== req_v) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        m0_bus.req   = 1'b0;
        m1_bus.req   = 1'b0;
        s_bus.resp   = 1'b0;
        s_bus.fault  = 1'b0;
    endtask

    task automatic drive(input int m, input logic [31:0] a, input logic w,
                         input logic [1:0] acc, input logic [31:0] wd);
        if (m == 0) begin
            m0_bus.addr = a; m0_bus.w_rb = w; m0_bus.acc = acc; m0_bus.wdata = wd; m0_bus.req = 1'b1;
        end else begin
            m1_bus.addr = a; m1_bus.w_rb = w; m1_bus.acc = acc; m1_bus.wdata = wd; m1_bus.req = 1'b1;
        end
    endtask

    task automatic respond(input logic [31:0] rd);
        s_bus.resp  = 1'b1;
        s_bus.rdata = rd;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " s_req"},   {31'd0, s_bus.req},   32'd0);
        check({tag, " s_addr"},  s_bus.addr,           32'd0);
        check({tag, " s_w_rb"},  {31'd0, s_bus.w_rb},  32'd0);
        check({tag, " s_acc"},   {30'd0, s_bus.acc},   32'd0);
        check({tag, " s_wdata"}, s_bus.wdata,          32'd0);
    endtask

    // Two masters request in the same cycle; 'first' is the expected winner.
    task automatic contend(input logic [31:0] a0, input logic [31:0] a1, input int first,
                           input logic [31:0] rd_a, input logic [31:0] rd_b);
        int n;
        logic [31:0] af, al;
        af = (first == 0) ? a0 : a1;
        al = (first == 0) ? a1 : a0;
        n = cyc;
        drive(0, a0, 1'b0, 2'd2, 32'd0);
        drive(1, a1, 1'b0, 2'd2, 32'd0);
        push(K_SREQ, n + 1, pack_req(af, 1'b0, 2'd2, 32'd0));
        step(); step(); step();
        respond(rd_a);
        push((first == 0) ? K_M0RESP : K_M1RESP, n + 3, {96'd0, rd_a});
        push(K_SREQ, n + 4, pack_req(al, 1'b0, 2'd2, 32'd0));
        step(); step();
        respond(rd_b);
        push((first == 0) ? K_M1RESP : K_M0RESP, n + 5, {96'd0, rd_b});
        step(); step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int second_first;
        m0_bus.req = 1'b0; m0_bus.addr = '0; m0_bus.w_rb = 1'b0; m0_bus.acc = '0; m0_bus.wdata = '0;
        m1_bus.req = 1'b0; m1_bus.addr = '0; m1_bus.w_rb = 1'b0; m1_bus.acc = '0; m1_bus.wdata = '0;
        s_bus.resp = 1'b0; s_bus.fault = 1'b0; s_bus.rdata = '0;

        // Reset state
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        #1;
        check_reset_outputs("reset");
        check("reset m0_resp",  {31'd0, m0_bus.resp},  32'd0);
        check("reset m1_resp",  {31'd0, m1_bus.resp},  32'd0);
        check("reset m0_fault", {31'd0, m0_bus.fault}, 32'd0);
        check("reset m1_fault", {31'd0, m1_bus.fault}, 32'd0);
        step();

        // Single m0 read, response three cycles after s_req
        n = cyc;
        drive(0, 32'h0000_0100, 1'b0, 2'd2, 32'd0);
        push(K_SREQ, n + 1, pack_req(32'h0000_0100, 1'b0, 2'd2, 32'd0));
        step(); step(); step(); step();
        respond(32'hDEAD_BEEF);
        push(K_M0RESP, n + 4, {96'd0, 32'hDEAD_BEEF});
        step(); step();

        // Contention, twice
        contend(32'h0000_0200, 32'h0000_0300, 0, 32'h0000_00A0, 32'h0000_00A1);
`ifdef BUS_ARB_RR_EN
        second_first = 1;
`else
        second_first = 0;
`endif
        contend(32'h0000_0204, 32'h0000_0304, second_first, 32'h0000_00B0, 32'h0000_00B1);

        // m1 write faults at decode; m0 then issues normally
        n = cyc;
        drive(1, 32'hF000_0000, 1'b1, 2'd2, 32'hCAFE_F00D);
        push(K_SREQ, n + 1, pack_req(32'hF000_0000, 1'b1, 2'd2, 32'hCAFE_F00D));
        step();
        s_bus.fault = 1'b1;
        push(K_M1FLT, n + 1, 128'd0);
        step();
        drive(0, 32'h0000_0400, 1'b0, 2'd1, 32'd0);
        push(K_SREQ, n + 3, pack_req(32'h0000_0400, 1'b0, 2'd1, 32'd0));
        step(); step();
        respond(32'h0000_1234);
        push(K_M0RESP, n + 4, {96'd0, 32'h0000_1234});
        step(); step();

        // m0 re-requests while outstanding
        n = cyc;
        drive(0, 32'h0000_0500, 1'b0, 2'd2, 32'd0);
        push(K_SREQ, n + 1, pack_req(32'h0000_0500, 1'b0, 2'd2, 32'd0));
        step(); step();
        drive(0, 32'h0000_0600, 1'b1, 2'd2, 32'h1111_2222);
        push(K_M0FLT, n + 2, 128'd0);
        step(); step();
        respond(32'h0000_0055);
        push(K_M0RESP, n + 4, {96'd0, 32'h0000_0055});
        step(); step(); step();

        // Reset while busy with m1 pending
        n = cyc;
        drive(0, 32'h0000_0700, 1'b0, 2'd2, 32'd0);
        push(K_SREQ, n + 1, pack_req(32'h0000_0700, 1'b0, 2'd2, 32'd0));
        step();
        drive(1, 32'h0000_0800, 1'b0, 2'd2, 32'd0);
        step();
        rst = 1'b1;
        respond(32'h0000_0077);
        step();
        rst = 1'b0;
        #1;
        check_reset_outputs("midreset");
        respond(32'h0000_0088);
        step();
        drive(0, 32'h0000_0900, 1'b0, 2'd3, 32'd0);
        push(K_SREQ, n + 5, pack_req(32'h0000_0900, 1'b0, 2'd3, 32'd0));
        step(); step();
        respond(32'h0000_0099);
        push(K_M0RESP, n + 6, {96'd0, 32'h0000_0099});
        step(); step(); step();

        expire(cyc + 1000);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
